// File: rtl/mc_control_fsm.sv
// Purpose : multi-cycle MIPS control sequencer; walks fetch/decode/execute/memory/writeback and drives every datapath select.
// Latency : R-type 4, LW 5, SW 4, BEQ 3, J 3 (ADDI 4 with MC_IMM_EN) cycles FETCH-to-FETCH with no memory wait.
// Backpres: FETCH, MEM_READ and MEM_WRITE hold while mem_ready is low; each low cycle adds one cycle. Optional macro: MC_IMM_EN.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
`ifdef MC_IMM_EN
        JUMP      = 4'd10,
        IMM_EXEC  = 4'd11,
        IMM_WB    = 4'd12
`else
        JUMP      = 4'd10
`endif
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    assign state = cur_state;

    // State register; reset forces INIT immediately, abandoning any stalled access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= INIT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and Moore output decode; FETCH's IR/PC loads and DECODE's illegal flag are the only input-dependent outputs.
    always_comb begin
        nxt_state     = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        case (cur_state)
            INIT: begin
                nxt_state = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    nxt_state = DECODE;
                end
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEM_ADDR;
                    OP_RTYPE:     nxt_state = EXECUTE;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
`ifdef MC_IMM_EN
                    OP_ADDI:      nxt_state = IMM_EXEC;
`else
                    OP_ADDI: begin
                        illegal_op = 1'b1;
                        nxt_state  = FETCH;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        nxt_state  = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nxt_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    nxt_state = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    nxt_state = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                nxt_state = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                nxt_state     = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                nxt_state = FETCH;
            end
`ifdef MC_IMM_EN
            IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nxt_state = IMM_WB;
            end
            IMM_WB: begin
                reg_write = 1'b1;
                nxt_state = FETCH;
            end
`endif
            default: begin
                // Unused encodings recover through INIT.
                nxt_state = INIT;
            end
        endcase
    end

endmodule
